// File: rtl/alu_seq.sv
// alu_seq: registered valid/ready ALU with flags and a multi-cycle shift-add multiplier
module alu_seq #(
    parameter int WIDTH = 8,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_n,
    output logic             flag_v,
    output logic             a_is_zero,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, MUL_BUSY, DONE} state_t;
    state_t state, state_n;
    logic accept, is_mul, last;
    logic [SHW-1:0] sh, m_cnt;
    logic [WIDTH:0] sum, dif, shl, shr;
    logic [WIDTH-1:0] res, flag_res, m_acc, m_cand, m_plier, m_step;
    logic c_n, v_n, add_v, sub_v;

    assign a_is_zero = ~|in_a;
    assign busy      = state == MUL_BUSY;
    assign out_valid = state == DONE;
    assign in_ready  = (state == IDLE) | (out_valid & out_ready);
    assign accept    = in_valid & in_ready;
    assign is_mul    = opcode == 4'hD;
    assign last      = m_cnt == SHW'(WIDTH - 1);

    assign sh    = in_b[SHW-1:0];
    assign sum   = {1'b0, in_a} + {1'b0, in_b} + (WIDTH+1)'(opcode == 4'hC && flag_c);
    // carry-out of A + ~B + 1 is the no-borrow flag
    assign dif   = {1'b0, in_a} + {1'b0, ~in_b} + (WIDTH+1)'(1);
    assign shl   = {1'b0, in_a} << sh;
    assign shr   = {in_a, 1'b0} >> sh;
    assign add_v = (in_a[WIDTH-1] == in_b[WIDTH-1]) & (sum[WIDTH-1] != in_a[WIDTH-1]);
    assign sub_v = (in_a[WIDTH-1] != in_b[WIDTH-1]) & (dif[WIDTH-1] != in_a[WIDTH-1]);
    assign flag_res = opcode == 4'hE ? dif[WIDTH-1:0] : res;
    assign m_step   = m_acc + (m_plier[0] ? m_cand : '0);

    always_comb begin
        res = in_a;
        c_n = flag_c;
        v_n = 1'b0;
        case (opcode)
            4'h2, 4'hC: begin res = sum[WIDTH-1:0]; c_n = sum[WIDTH]; v_n = add_v; end
            4'h3: res = in_a & in_b;
            4'h4: res = in_a ^ in_b;
            4'h5: res = in_b;
            4'h8: begin res = dif[WIDTH-1:0]; c_n = dif[WIDTH]; v_n = sub_v; end
            4'h9: res = in_a | in_b;
            4'hA: begin res = shl[WIDTH-1:0]; c_n = shl[WIDTH]; end
            4'hB: begin res = shr[WIDTH:1]; c_n = shr[0]; end
            4'hE: begin c_n = dif[WIDTH]; v_n = sub_v; end
            default: ;
        endcase
    end

    always_comb begin
        state_n = state;
        if (accept)
            state_n = is_mul ? MUL_BUSY : DONE;
        else if (busy && last)
            state_n = DONE;
        else if (out_valid && out_ready)
            state_n = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_out <= '0;
            {flag_z, flag_c, flag_n, flag_v} <= '0;
            {m_acc, m_cand, m_plier} <= '0;
            m_cnt <= '0;
        end else if (accept && is_mul) begin
            m_acc   <= '0;
            m_cand  <= in_a;
            m_plier <= in_b;
            m_cnt   <= '0;
        end else if (accept) begin
            alu_out <= res;
            flag_z  <= ~|flag_res;
            flag_n  <= flag_res[WIDTH-1];
            flag_c  <= c_n;
            flag_v  <= v_n;
        end else if (busy) begin
            m_acc   <= m_step;
            m_cand  <= m_cand << 1;
            m_plier <= m_plier >> 1;
            m_cnt   <= m_cnt + 1'b1;
            if (last) begin
                alu_out <= m_step;
                flag_z  <= ~|m_step;
                flag_n  <= m_step[WIDTH-1];
                flag_c  <= 1'b0;
                flag_v  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed-vector bench for alu_seq (WIDTH=8)
module tb_alu_seq;
    logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
    logic in_ready, out_valid, flag_z, flag_c, flag_n, flag_v, a_is_zero, busy;
    logic [7:0] in_a = 0, in_b = 0, alu_out;
    logic [3:0] opcode = 0;
    int checks = 0, failures = 0;

    alu_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .opcode(opcode), .out_valid(out_valid),
        .out_ready(out_ready), .alu_out(alu_out), .flag_z(flag_z), .flag_c(flag_c),
        .flag_n(flag_n), .flag_v(flag_v), .a_is_zero(a_is_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    // {alu_out, Z, C, N, V, out_valid}
    wire [12:0] obs = {alu_out, flag_z, flag_c, flag_n, flag_v, out_valid};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        int n = 0;
        in_a = a; in_b = b; opcode = op; in_valid = 1;
        while (!in_ready && n < 50) begin step(); n++; end
        if (!in_ready) begin
            checks++; failures++;
            $display("FAIL issue_timeout: in_ready=%b required 1", in_ready);
        end
        step();
        in_valid = 0;
    endtask

    task automatic drain();
        out_ready = 1;
        step();
        out_ready = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; in_a = 0;
        step(); step();
        rst_n = 1;
        checks++;
        if ({obs, busy, in_ready, a_is_zero} !== {13'h0, 1'b0, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL reset_state: got %h/%b/%b/%b required 0000/0/1/1", obs, busy, in_ready, a_is_zero);
        end
        in_a = 8'h05; #1;
        checks++;
        if (a_is_zero !== 1'b0) begin failures++; $display("FAIL a_is_zero: got %b required 0", a_is_zero); end
    endtask

    task automatic test_add_sub();
        issue(8'hF0, 8'h20, 4'h2);
        checks++;
        if ({obs, in_ready} !== {8'h10, 5'b01001, 1'b0}) begin
            failures++; $display("FAIL add_carry: got %h in_ready=%b required %h in_ready=0", obs, in_ready, {8'h10, 5'b01001});
        end
        drain();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_idle: out_valid=%b required 0", out_valid); end
        issue(8'h7F, 8'h01, 4'h2);
        checks++;
        if (obs !== {8'h80, 5'b00111}) begin failures++; $display("FAIL add_overflow: got %h required %h", obs, {8'h80, 5'b00111}); end
        drain();
        issue(8'h05, 8'h05, 4'h8);
        checks++;
        if (obs !== {8'h00, 5'b11001}) begin failures++; $display("FAIL sub_zero: got %h required %h", obs, {8'h00, 5'b11001}); end
        drain();
        issue(8'h03, 8'h04, 4'hE);
        checks++;
        if (obs !== {8'h03, 5'b00101}) begin failures++; $display("FAIL cmp_less: got %h required %h", obs, {8'h03, 5'b00101}); end
        drain();
    endtask

    task automatic test_mul();
        int cyc = 0, bad = 0;
        issue(8'h0D, 8'h0B, 4'hD);
        while (!out_valid && cyc < 20) begin
            if (!busy || in_ready) bad++;
            step(); cyc++;
        end
        checks++;
        if (cyc != 8 || bad != 0) begin
            failures++; $display("FAIL mul_latency: cycles=%0d busy_errors=%0d required 8/0", cyc, bad);
        end
        checks++;
        if ({obs, busy} !== {8'h8F, 5'b00101, 1'b0}) begin
            failures++; $display("FAIL mul_result: got %h busy=%b required %h busy=0", obs, busy, {8'h8F, 5'b00101});
        end
        drain();
        issue(8'h10, 8'h10, 4'hD);
        cyc = 0;
        while (!out_valid && cyc < 20) begin step(); cyc++; end
        checks++;
        if (obs !== {8'h00, 5'b10001}) begin failures++; $display("FAIL mul_zero: got %h required %h", obs, {8'h00, 5'b10001}); end
        drain();
    endtask

    task automatic test_back_to_back();
        issue(8'hFF, 8'h01, 4'h2);
        checks++;
        if (obs !== {8'h00, 5'b11001}) begin failures++; $display("FAIL add_wrap: got %h required %h", obs, {8'h00, 5'b11001}); end
        out_ready = 1; in_valid = 1;
        in_a = 8'h00; in_b = 8'h00; opcode = 4'hC; step();
        checks++;
        if (obs !== {8'h01, 5'b00001}) begin failures++; $display("FAIL adc_carry_in: got %h required %h", obs, {8'h01, 5'b00001}); end
        in_a = 8'h81; in_b = 8'h09; opcode = 4'hA; step();
        checks++;
        if (obs !== {8'h02, 5'b01001}) begin failures++; $display("FAIL shl_mod: got %h required %h", obs, {8'h02, 5'b01001}); end
        in_a = 8'h00; in_b = 8'h5A; opcode = 4'h5; step();
        checks++;
        if (obs !== {8'h5A, 5'b01001}) begin failures++; $display("FAIL passb_keep_c: got %h required %h", obs, {8'h5A, 5'b01001}); end
        in_a = 8'h80; in_b = 8'h03; opcode = 4'hB; step();
        checks++;
        if (obs !== {8'h10, 5'b00001}) begin failures++; $display("FAIL shr: got %h required %h", obs, {8'h10, 5'b00001}); end
        in_a = 8'h81; in_b = 8'h08; opcode = 4'hA; step();
        checks++;
        if (obs !== {8'h81, 5'b00101}) begin failures++; $display("FAIL shl_zero_amt: got %h required %h", obs, {8'h81, 5'b00101}); end
        in_valid = 0; step(); out_ready = 0;
    endtask

    task automatic test_backpressure();
        int bad = 0;
        issue(8'h11, 8'h22, 4'h2);
        in_a = 8'hF0; in_b = 8'hFF; opcode = 4'h4; in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            if (obs !== {8'h33, 5'b00001} || in_ready !== 1'b0) bad++;
            step();
        end
        checks++;
        if (bad != 0 || obs !== {8'h33, 5'b00001}) begin
            failures++; $display("FAIL hold_stable: got %h errors=%0d required %h", obs, bad, {8'h33, 5'b00001});
        end
        out_ready = 1; step();
        checks++;
        if (obs !== {8'h0F, 5'b00001}) begin failures++; $display("FAIL stream_xor: got %h required %h", obs, {8'h0F, 5'b00001}); end
        in_a = 8'hF0; in_b = 8'h3C; opcode = 4'h3; step();
        checks++;
        if (obs !== {8'h30, 5'b00001}) begin failures++; $display("FAIL stream_and: got %h required %h", obs, {8'h30, 5'b00001}); end
        in_a = 8'h0F; in_b = 8'hA0; opcode = 4'h9; step();
        checks++;
        if (obs !== {8'hAF, 5'b00101}) begin failures++; $display("FAIL stream_or: got %h required %h", obs, {8'hAF, 5'b00101}); end
        in_valid = 0; step(); out_ready = 0;
    endtask

    task automatic test_reset_mul();
        issue(8'h0D, 8'h0B, 4'hD);
        step(); step(); step();
        rst_n = 0; step();
        checks++;
        if ({obs, busy, in_ready} !== {13'h0, 1'b0, 1'b1}) begin
            failures++; $display("FAIL reset_abort: got %h busy=%b in_ready=%b required 0000/0/1", obs, busy, in_ready);
        end
        rst_n = 1;
        issue(8'h01, 8'h02, 4'h2);
        checks++;
        if (obs !== {8'h03, 5'b00001}) begin failures++; $display("FAIL add_after_reset: got %h required %h", obs, {8'h03, 5'b00001}); end
        drain();
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mul();
        test_back_to_back();
        test_backpressure();
        test_reset_mul();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the 8-opcode datapath ALU.
- Adds a 4-bit opcode space (SUB, OR, shifts, ADC, CMP), a multi-cycle shift-add multiplier, and registered Z/C/N/V flags.
- Uses valid/ready handshakes on both input and output.
- Sits between the accumulator/operand registers and the writeback mux of the CPU datapath.

Parameters:
- WIDTH, 8, operand/result width in bits (≥4).
- SHW, $clog2(WIDTH), shift-amount width; derived, do not override.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept an operation this cycle.
- in_a  in  WIDTH  operand A (accumulator).
- in_b  in  WIDTH  operand B (memory/data).
- opcode  in  4  operation select.
- out_valid  out  1  alu_out/flags hold a completed result.
- out_ready  in  1  consumer accepts the result.
- alu_out  out  WIDTH  registered result.
- flag_z, flag_c, flag_n, flag_v  out  1 each  registered flags.
- a_is_zero  out  1  combinational ~|in_a, independent of handshake.
- busy  out  1  high while in MUL_BUSY.

Behaviour:
- Reset (rst_n low at clk edge): state=IDLE, alu_out=0, all flags=0, out_valid=0, busy=0, multiplier counter/accumulators=0. Reset has priority over everything and aborts any in-flight op. in_ready=1 the cycle after reset.
- Accept occurs when in_valid & in_ready at a clk edge; in_a, in_b and opcode are captured at that edge.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Opcodes:
  - 0000/0001/0110/0111/1111: pass A.
  - 0010: ADD, A+B.
  - 0011: AND.
  - 0100: XOR.
  - 0101: pass B.
  - 1000: SUB, A-B.
  - 1001: OR.
  - 1010: SHL, A<<B[SHW-1:0].
  - 1011: SHR logical, A>>B[SHW-1:0].
  - 1100: ADC, A+B+flag_c.
  - 1101: MUL, low WIDTH bits of A*B.
  - 1110: CMP, computes A-B for flags only; alu_out=A.
- Shift amount uses only the low SHW bits of B (modulo WIDTH); upper B bits are ignored.
- Single-cycle ops: on the accept edge, alu_out/flags load and state goes to DONE. out_valid=1 the following cycle (latency 1).
- MUL: accept edge → MUL_BUSY with count=0. Each edge in MUL_BUSY processes one multiplier bit (shift-add). After WIDTH edges in MUL_BUSY, load the result and go to DONE.
  - out_valid rises exactly WIDTH cycles after the accept edge.
  - in_ready=0 and busy=1 throughout MUL_BUSY.
- DONE: out_valid=1. alu_out and flags are held stable until out_ready=1.
  - out_ready=1 with in_valid=1: the new op is accepted on the same edge (back-to-back, throughput 1/cycle for single-cycle ops).
  - out_ready=1 with in_valid=0: return to IDLE, out_valid=0.
- Flags update only when a result loads:
  - flag_z = (result==0). For CMP, Z is taken from A-B, not from alu_out.
  - flag_n = result MSB (CMP: MSB of A-B).
  - flag_c:
    - ADD/ADC: carry-out.
    - SUB/CMP: no-borrow (1 when A≥B unsigned).
    - SHL: last bit shifted out.
    - SHR: last bit shifted out.
    - Shift by 0: C=0.
    - Logic/pass ops: C unchanged.
    - MUL: C=0.
  - flag_v:
    - ADD/ADC/SUB/CMP: signed overflow.
    - All other ops: V=0.
- ADC reads the flag_c value from the prior completed op, including a result still held in DONE that is being accepted on the same edge.
- in_valid while in_ready=0 is ignored; the requester holds its inputs.

Test Plan:
- WIDTH=8, ADD 0xF0+0x20 → alu_out=0x10, C=1, Z=0, out_valid one cycle after accept. ADD 0x7F+0x01 → 0x80, V=1, N=1, C=0.
- SUB 0x05-0x05 → 0x00, Z=1, C=1. CMP A=0x03, B=0x04 → alu_out=0x03, C=0, N=1, Z=0, V=0.
- MUL 0x0D*0x0B → alu_out=0x8F; out_valid exactly 8 cycles after accept; in_ready=0 and busy=1 for those 8 cycles. MUL 0x10*0x10 → 0x00, Z=1.
- ADD 0xFF+0x01 (→0x00, C=1, Z=1) followed back-to-back by ADC 0x00+0x00 → 0x01, C=0. SHL 0x81 by B=0x09 (amount 1) → 0x02, C=1.
- Backpressure: ADD result held with out_ready=0 for 3 cycles → alu_out/flags/out_valid stable, in_ready=0. Then XOR, AND, OR streamed with out_ready=1 → one result per cycle, correct order.
- Assert rst_n=0 at cycle 4 of a MUL → next cycle out_valid=0, busy=0, flags=0, in_ready=1. A following ADD 0x01+0x02 → 0x03.
